// File: rtl/reduction_config_ctrl.sv
// rtl/reduction_config_ctrl.sv - adder-switch config sequencer
// Double-buffered per-switch config with RUN/DRAIN gating of switch valids.
module reduction_config_ctrl #(
  parameter int NUM_AS    = 8,
  parameter int SEL_IN    = 2,
  parameter int CFG_W     = 4 + SEL_IN,
  parameter int DRAIN_CYC = 6
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     i_cfg_valid,
  input  logic [CFG_W-1:0]         i_cfg_data,
  output logic                     o_cfg_ready,
  input  logic                     i_start,
  input  logic [15:0]              i_num_folds,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  output logic [NUM_AS-1:0]        o_as_valid,
  output logic [NUM_AS-1:0]        o_as_add_en,
  output logic [3*NUM_AS-1:0]      o_as_cmd,
  output logic [SEL_IN*NUM_AS-1:0] o_as_sel,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_start_err
);

  localparam int CNT_W = $clog2(NUM_AS + 1);
  localparam int IDX_W = (NUM_AS > 1) ? $clog2(NUM_AS) : 1;
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_AS);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   shadow [NUM_AS];
  logic [CNT_W-1:0]   shadow_cnt;
  logic [15:0]        rem;
  logic [DRN_W-1:0]   drain_cnt;
  logic               shadow_full;
  logic               swap;
  logic               cfg_fire;

  assign shadow_full = (shadow_cnt == FULL_CNT);
  assign swap        = (state == S_IDLE) && i_start && shadow_full;
  assign cfg_fire    = i_cfg_valid && !shadow_full;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (swap) state_nxt = (i_num_folds != 16'd0) ? S_RUN : S_DRAIN;
      S_RUN:   if (i_data_valid && rem == 16'd1) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRN_ONE) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_cfg_ready  = !shadow_full;
    o_data_ready = (state == S_RUN);
    o_busy       = (state != S_IDLE);
    o_as_valid   = (state == S_RUN && i_data_valid) ? {NUM_AS{1'b1}} : {NUM_AS{1'b0}};
  end

  // Shadow cannot be written while full, so a swap never races a cfg write.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cnt <= '0;
      for (int k = 0; k < NUM_AS; k++) shadow[k] <= '0;
    end else if (swap) begin
      shadow_cnt <= '0;
    end else if (cfg_fire) begin
      shadow[shadow_cnt[IDX_W-1:0]] <= i_cfg_data;
      shadow_cnt                    <= shadow_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      o_as_add_en <= '0;
      o_as_cmd    <= '0;
      o_as_sel    <= '0;
    end else if (swap) begin
      for (int k = 0; k < NUM_AS; k++) begin
        o_as_add_en[k]              <= shadow[k][CFG_W-1];
        o_as_cmd[3*k +: 3]          <= shadow[k][CFG_W-2 -: 3];
        o_as_sel[SEL_IN*k +: SEL_IN] <= shadow[k][SEL_IN-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      drain_cnt   <= '0;
      o_done      <= 1'b0;
      o_start_err <= 1'b0;
    end else begin
      if (swap)
        rem <= i_num_folds;
      else if (state == S_RUN && i_data_valid)
        rem <= rem - 16'd1;

      if (state_nxt == S_DRAIN && state != S_DRAIN)
        drain_cnt <= DRN_LOAD;
      else if (state == S_DRAIN)
        drain_cnt <= drain_cnt - DRN_ONE;

      o_done      <= (state == S_DRAIN) && (drain_cnt == DRN_ONE);
      o_start_err <= i_start && !swap;
    end
  end

endmodule
